// File: rtl/ag32gbd_reg_pkg.sv
// Shared encodings for the register responder: FSM states, client ids, default widths,
// and the sampler threshold address map (16 channels x low/mid/high from 0x200).
package ag32gbd_reg_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    localparam logic [9:0] THR_BASE   = 10'h200;
    localparam int         THR_STRIDE = 3;
    localparam int         THR_COUNT  = 16;

    localparam logic CL_A = 1'b0;
    localparam logic CL_B = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_READ    = 4'b0010,
        S_CAPTURE = 4'b0100,
        S_DONE    = 4'b1000
    } state_e;

    // lvl: 0 = low, 1 = mid, 2 = high
    function automatic logic [9:0] thr_addr(input logic [3:0] idx, input logic [1:0] lvl);
        return THR_BASE + 10'(idx) * 10'(THR_STRIDE) + 10'(lvl);
    endfunction

endpackage

// File: rtl/ag32gbd_reg_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port (1 cycle).
// No backpressure; both ports accept every cycle.
module ag32gbd_reg_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // Contents are deliberately not reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ag32gbd_reg_responder.sv
// Two-client 4-phase register read responder with round-robin grant and host write port.
// Done 2 cycles after grant; one read in flight, writes never stall.
module ag32gbd_reg_responder
    import ag32gbd_reg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              sys_clock,
    input  logic              sys_reset,
    input  logic              ReqA,
    input  logic [ADDR_W-1:0] AddrA,
    output logic [DATA_W-1:0] DataA,
    output logic              DoneA,
    input  logic              ReqB,
    input  logic [ADDR_W-1:0] AddrB,
    output logic [DATA_W-1:0] DataB,
    output logic              DoneB,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    output logic              Busy
);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        armed_q, armed_d;
    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;
    logic              busy_q, busy_d;

    logic [1:0]        req;
    logic [1:0]        elig;
    logic              grant;
    logic [DATA_W-1:0] ram_rdata;

    assign req = {ReqB, ReqA};

    ag32gbd_reg_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (sys_clock),
        .wr_en   (WrEn),
        .wr_addr (WrAddr),
        .wr_data (WrData),
        .rd_en   (state_q == S_READ),
        .rd_addr (rd_addr_q),
        .rd_data (ram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        rd_addr_d = rd_addr_q;
        done_d    = done_q;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        // A client must be seen idle (Req low) before it can be granted again,
        // so a Req held across reset or completion is not treated as new.
        armed_d   = armed_q | ~req;
        elig      = req & ~done_q & armed_q;
        grant     = CL_A;

        case (state_q)
            S_IDLE: begin
                if (|elig) begin
                    grant     = (&elig) ? ~last_q : elig[1];
                    owner_d   = grant;
                    rd_addr_d = (grant == CL_B) ? AddrB : AddrA;
                    armed_d[grant] = 1'b0;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (req[owner_q]) begin
                    if (owner_q == CL_B) begin
                        data_b_d = ram_rdata;
                    end else begin
                        data_a_d = ram_rdata;
                    end
                    done_d[owner_q] = 1'b1;
                    last_d          = owner_q;
                    state_d         = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (!req[owner_q]) begin
                    done_d[owner_q] = 1'b0;
                    state_d         = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            state_q   <= S_IDLE;
            owner_q   <= CL_A;
            last_q    <= CL_B;
            rd_addr_q <= '0;
            done_q    <= '0;
            armed_q   <= '0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            rd_addr_q <= rd_addr_d;
            done_q    <= done_d;
            armed_q   <= armed_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            busy_q    <= busy_d;
        end
    end

    assign DataA = data_a_q;
    assign DataB = data_b_q;
    assign DoneA = done_q[CL_A];
    assign DoneB = done_q[CL_B];
    assign Busy  = busy_q;

endmodule

// File: tb/tb_ag32gbd_reg_responder.sv
// Directed bench for the register responder: handshake timing, round-robin, abandon,
// read-first collision, reset mid-transaction and back-to-back sampler reads.
module tb_ag32gbd_reg_responder;
    import ag32gbd_reg_pkg::*;

    logic       sys_clock = 1'b0;
    logic       sys_reset = 1'b1;
    logic       ReqA = 1'b0, ReqB = 1'b0, WrEn = 1'b0;
    logic [9:0] AddrA = '0, AddrB = '0, WrAddr = '0;
    logic [7:0] WrData = '0;
    logic [7:0] DataA, DataB;
    logic       DoneA, DoneB, Busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int done_cyc [3];
    logic [7:0] smp_val [3];

    ag32gbd_reg_responder #(.ADDR_W(10), .DATA_W(8)) dut (
        .sys_clock (sys_clock),
        .sys_reset (sys_reset),
        .ReqA      (ReqA),
        .AddrA     (AddrA),
        .DataA     (DataA),
        .DoneA     (DoneA),
        .ReqB      (ReqB),
        .AddrB     (AddrB),
        .DataB     (DataB),
        .DoneB     (DoneB),
        .WrEn      (WrEn),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .Busy      (Busy)
    );

    always #5 sys_clock = ~sys_clock;
    always @(posedge sys_clock) cyc <= cyc + 1;

    task automatic step();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [7:0] d);
        WrEn = 1'b1; WrAddr = a; WrData = d;
        step();
        WrEn = 1'b0;
    endtask

    initial begin
        smp_val[0] = 8'hA1; smp_val[1] = 8'hB2; smp_val[2] = 8'hC3;

        step(); step();
        chk("rst_data_a", DataA, 0);
        chk("rst_done_a", DoneA, 0);
        chk("rst_data_b", DataB, 0);
        chk("rst_done_b", DoneB, 0);
        chk("rst_busy",   Busy,  0);
        sys_reset = 1'b0;
        step();

        wr(10'h100, 8'h11);
        wr(10'h101, 8'h22);
        wr(10'h201, 8'h5A);
        wr(10'h210, 8'h33);
        for (int i = 0; i < 3; i++) wr(thr_addr(4'd1, 2'(i)), smp_val[i]);

        // Simultaneous requests from reset: A first.
        ReqA = 1'b1; AddrA = 10'h100; ReqB = 1'b1; AddrB = 10'h101;
        step(); step(); step();
        chk("tie1_done_a", DoneA, 1);
        chk("tie1_data_a", DataA, 8'h11);
        chk("tie1_done_b", DoneB, 0);
        ReqA = 1'b0;
        step();
        chk("tie1_drop_a", DoneA, 0);
        // A re-requests while B is still waiting: B must win this tie.
        ReqA = 1'b1;
        step(); step(); step();
        chk("tie2_done_b", DoneB, 1);
        chk("tie2_data_b", DataB, 8'h22);
        chk("tie2_done_a", DoneA, 0);
        ReqB = 1'b0;
        step();
        chk("tie2_drop_b", DoneB, 0);
        step(); step(); step();
        chk("tie3_done_a", DoneA, 1);
        chk("tie3_data_a", DataA, 8'h11);
        chk("tie3_data_b_hold", DataB, 8'h22);
        ReqA = 1'b0;
        step();

        // Basic read of 0x201 with latency check.
        ReqA = 1'b1; AddrA = 10'h201;
        step();
        chk("rd_busy_grant", Busy, 1);
        chk("rd_done_n",   DoneA, 0);
        step();
        chk("rd_done_n1",  DoneA, 0);
        step();
        chk("rd_done_n2",  DoneA, 1);
        chk("rd_data",     DataA, 8'h5A);
        AddrA = 10'h000;
        step();
        chk("rd_hold_done", DoneA, 1);
        chk("rd_hold_data", DataA, 8'h5A);
        ReqA = 1'b0;
        step();
        chk("rd_drop_done", DoneA, 0);
        chk("rd_drop_busy", Busy,  0);
        chk("rd_drop_data", DataA, 8'h5A);

        // Abandoned request.
        ReqA = 1'b1; AddrA = 10'h100;
        step();
        ReqA = 1'b0;
        step();
        chk("ab_busy_mid", Busy, 1);
        step();
        chk("ab_busy",  Busy,  0);
        chk("ab_done",  DoneA, 0);
        chk("ab_data",  DataA, 8'h5A);
        step();
        chk("ab_done2", DoneA, 0);

        // Write at the S_READ edge returns old data.
        ReqA = 1'b1; AddrA = 10'h210;
        step();
        WrEn = 1'b1; WrAddr = 10'h210; WrData = 8'h77;
        step();
        WrEn = 1'b0;
        step();
        chk("rf_old_done", DoneA, 1);
        chk("rf_old_data", DataA, 8'h33);
        ReqA = 1'b0;
        step();
        // Write on the grant edge returns new data.
        ReqA = 1'b1; WrEn = 1'b1; WrAddr = 10'h210; WrData = 8'h88;
        step();
        WrEn = 1'b0;
        step(); step();
        chk("rf_new_data", DataA, 8'h88);
        ReqA = 1'b0;
        step();

        // Reset while in S_DONE.
        ReqA = 1'b1; AddrA = 10'h201;
        step(); step(); step();
        chk("rs_pre_done", DoneA, 1);
        #2 sys_reset = 1'b1;
        #1;
        chk("rs_async_done", DoneA, 0);
        chk("rs_async_data", DataA, 0);
        chk("rs_async_busy", Busy,  0);
        step();
        sys_reset = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("rs_held_done", DoneA, 0);
        chk("rs_held_busy", Busy,  0);
        ReqA = 1'b0;
        step();
        ReqA = 1'b1;
        step(); step(); step();
        chk("rs_new_done", DoneA, 1);
        chk("rs_new_data", DataA, 8'h5A);
        ReqA = 1'b0;
        step();

        // Sampler-style back-to-back reads, request dropped as Done is seen.
        for (int i = 0; i < 3; i++) begin
            ReqA = 1'b1; AddrA = thr_addr(4'd1, 2'(i));
            step(); step();
            chk("smp_early", DoneA, 0);
            step();
            chk("smp_done", DoneA, 1);
            chk("smp_data", DataA, smp_val[i]);
            done_cyc[i] = cyc;
            ReqA = 1'b0;
            step();
            chk("smp_drop", DoneA, 0);
        end
        chk("smp_period1", done_cyc[1] - done_cyc[0], 4);
        chk("smp_period2", done_cyc[2] - done_cyc[1], 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
